// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the memory stage: word type, controller states, word offset.
package cpu_types_pkg;
  localparam int WORD_OFF = 2;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, REQ, DONE} memctl_state_t;
endpackage

// File: rtl/ll_link_reg.sv
// LL/SC link register: holds the linked word address and decides set/clear priority.
module ll_link_reg #(
  parameter int WORD_W   = 32,
  parameter int BYTE_OFF = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              set_i,
  input  logic [WORD_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic              st_i,
  input  logic [WORD_W-1:0] st_addr_i,
  input  logic              snp_i,
  input  logic [WORD_W-1:0] snp_addr_i,
  input  logic [WORD_W-1:0] chk_addr_i,
  output logic              chk_ok_o
);
  localparam int AW = WORD_W - BYTE_OFF;

  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          snp_hit, st_hit;

  // Shifting the whole word drops the byte offset without leaving bits unread.
  function automatic logic word_eq(input logic [WORD_W-1:0] a, input logic [AW-1:0] w);
    return (a >> BYTE_OFF) == {{BYTE_OFF{1'b0}}, w};
  endfunction

  assign snp_hit  = snp_i && word_eq(snp_addr_i, addr_q);
  assign st_hit   = st_i && word_eq(st_addr_i, addr_q);
  // A same-cycle matching invalidate makes the SC check fail.
  assign chk_ok_o = valid_q && word_eq(chk_addr_i, addr_q) && !snp_hit;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    // LL data is newer than any invalidate arriving in the same cycle.
    if (set_i) begin
      valid_d = 1'b1;
      addr_d  = AW'(set_addr_i >> BYTE_OFF);
    end else if (clr_i || snp_hit || st_hit) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: issues dcache requests from registered EX/MEM state, stalls until dhit,
// returns load data / SC status, and tracks the LL link.
module mem_access_ctrl
  import cpu_types_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int BYTE_OFF = WORD_OFF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dren_i,
  input  logic              dwen_i,
  input  logic              ll_i,
  input  logic              sc_i,
  input  logic              halt_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              snp_inv,
  input  logic [WORD_W-1:0] snp_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              pipe_en,
  output logic [WORD_W-1:0] load_data_o,
  output logic              mem_done_o,
  output logic              halt_o
);
  memctl_state_t     state_q, state_d;
  logic [WORD_W-1:0] req_addr_q, req_addr_d, req_data_q, req_data_d;
  logic [WORD_W-1:0] load_data_q, load_data_d;
  logic              req_rd_q, req_rd_d, req_wr_q, req_wr_d;
  logic              req_ll_q, req_ll_d, req_sc_q, req_sc_d;
  logic              halt_q, halt_d;
  logic              mem_op, sc_ok, hit_now, idle_run;

  assign mem_op   = dren_i || dwen_i;
  assign hit_now  = (state_q == REQ) && dhit;
  assign idle_run = (state_q == IDLE) && !halt_q && !mem_op;

  ll_link_reg #(.WORD_W(WORD_W), .BYTE_OFF(BYTE_OFF)) u_link (
    .CLK        (CLK),
    .nRST       (nRST),
    .set_i      (hit_now && req_ll_q),
    .set_addr_i (req_addr_q),
    .clr_i      (hit_now && req_sc_q),
    .st_i       (hit_now && req_wr_q),
    .st_addr_i  (req_addr_q),
    .snp_i      (snp_inv),
    .snp_addr_i (snp_addr),
    .chk_addr_i (addr_i),
    .chk_ok_o   (sc_ok)
  );

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_rd_d    = req_rd_q;
    req_wr_d    = req_wr_q;
    req_ll_d    = req_ll_q;
    req_sc_d    = req_sc_q;
    load_data_d = load_data_q;
    halt_d      = halt_q;
    case (state_q)
      IDLE: if (!halt_q) begin
        if (mem_op) begin
          req_addr_d = addr_i;
          req_data_d = wdata_i;
          req_rd_d   = dren_i;
          req_wr_d   = dwen_i;
          req_ll_d   = ll_i;
          req_sc_d   = sc_i;
          if (sc_i && !sc_ok) begin
            load_data_d = '0;
            state_d     = DONE;
          end else begin
            state_d = REQ;
          end
        end else if (halt_i) begin
          halt_d = 1'b1;
        end
      end
      REQ: if (dhit) begin
        if (req_sc_q)      load_data_d = WORD_W'(1);
        else if (req_rd_q) load_data_d = dmemload;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_rd_q    <= 1'b0;
      req_wr_q    <= 1'b0;
      req_ll_q    <= 1'b0;
      req_sc_q    <= 1'b0;
      load_data_q <= '0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_rd_q    <= req_rd_d;
      req_wr_q    <= req_wr_d;
      req_ll_q    <= req_ll_d;
      req_sc_q    <= req_sc_d;
      load_data_q <= load_data_d;
      halt_q      <= halt_d;
    end
  end

  assign dmemREN     = (state_q == REQ) && req_rd_q;
  assign dmemWEN     = (state_q == REQ) && req_wr_q;
  assign dmemaddr    = req_addr_q;
  assign dmemstore   = req_data_q;
  assign load_data_o = load_data_q;
  assign halt_o      = halt_q;
  // The halting instruction itself still lets the pipe advance; the stall starts next cycle.
  assign pipe_en     = (state_q == DONE) || idle_run;
  assign mem_done_o  = (state_q == DONE) || (idle_run && !halt_i && nRST);
endmodule
